// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Define MD_SIGNED_EN to add signed MULT/DIV (OP[1]=1); default build is unsigned only.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic             HI_WE,
  input  logic             LO_WE,
  input  logic [WIDTH-1:0] WDATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ZERO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d, q_q, q_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             done_q, done_d, dz_q, dz_d;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MD_SIGNED_EN
  assign sgn_a = OP[1] & A[WIDTH-1];
  assign sgn_b = OP[1] & B[WIDTH-1];
`else
  logic unused_op;
  assign unused_op = OP[1];
  assign sgn_a     = 1'b0;
  assign sgn_b     = 1'b0;
`endif

  // Iterations always run on magnitudes; signs are reapplied at FIN.
  assign a_mag = sgn_a ? (~A + 1'b1) : A;
  assign b_mag = sgn_b ? (~B + 1'b1) : B;

  logic [WIDTH-1:0]   b_sel, rem_sub, quo_res, rem_res;
  logic [WIDTH:0]     add_sum, rem_sh;
  logic               rem_ge, b_zero;
  logic [2*WIDTH-1:0] prod, mul_res;

  assign b_sel   = q_q[0] ? b_q : {WIDTH{1'b0}};
  assign add_sum = {1'b0, p_q} + {1'b0, b_sel};
  assign rem_sh  = {p_q, q_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - b_q;
  assign b_zero  = (b_q == '0);
  assign prod    = {p_q, q_q};
  assign mul_res = neg_res_q ? (~prod + 1'b1) : prod;
  assign quo_res = neg_res_q ? (~q_q + 1'b1) : q_q;
  assign rem_res = neg_rem_q ? (~p_q + 1'b1) : p_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    q_d       = q_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (HI_WE) hi_d = WDATA;
        if (LO_WE) lo_d = WDATA;
        if (START) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          a_d       = A;
          b_d       = b_mag;
          is_div_d  = OP[0];
          neg_res_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          p_d       = '0;
          q_d       = a_mag;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIN;
        if (is_div_q) begin
          // Restoring step: remainder fits WIDTH bits after the conditional subtract.
          p_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], rem_ge};
        end else begin
          p_d = add_sum[WIDTH:1];
          q_d = {add_sum[0], q_q[WIDTH-1:1]};
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = mul_res;
        end else if (b_zero) begin
          hi_d = a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_res;
          lo_d = quo_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      q_q       <= q_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  // BUSY covers the iteration cycles; the FIN cycle only commits the result.
  assign BUSY     = (state_q == S_CALC);
  assign DONE     = done_q;
  assign DIV_ZERO = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + random checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;
`ifdef MD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b, wdata;
  logic          start, hi_we, lo_we;
  logic [1:0]    op;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int compared   = 0;
  int mismatched = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .A(a), .B(b), .START(start), .OP(op),
    .HI_WE(hi_we), .LO_WE(lo_we), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .DIV_ZERO(div_zero), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {div_zero, hi, lo} computed with plain language arithmetic.
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] pr;
    int          xi, yi;
    if (!o[0]) begin
      if (SGN && o[1]) begin
        sx = $signed(x);
        sy = $signed(y);
        pr = sx * sy;
      end else begin
        pr = {32'h0, x} * {32'h0, y};
      end
      return {1'b0, pr};
    end
    if (y == 32'h0) return {1'b1, x, 32'hFFFFFFFF};
    if (SGN && o[1]) begin
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
      xi = x;
      yi = y;
      return {1'b0, 32'(xi % yi), 32'(xi / yi)};
    end
    return {1'b0, x % y, x / y};
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [64:0] exp, input int n0, input int nb0);
    int n;
    int nb;
    n  = n0;
    nb = nb0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) nb++;
      step();
      n++;
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_busy_cycles"}, nb, 32);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    check({tag, "_divzero"}, {31'b0, div_zero}, {31'b0, exp[64]});
  endtask

  initial begin
    logic dseen;
    rst = 1'b1; a = '0; b = '0; wdata = '0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;

    // Reset state
    step(); step();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_flags", {29'b0, busy, done, div_zero}, 32'h0);
    rst = 1'b0;
    repeat (5) step();
    check("idle_hi", hi, 32'h0);
    check("idle_lo", lo, 32'h0);
    check("idle_flags", {29'b0, busy, done, div_zero}, 32'h0);

    // Full-scale MULTU, DONE is a single pulse
    start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", {1'b0, 64'hFFFFFFFE_00000001}, 0, 0);
    step();
    check("done_pulse", {31'b0, done}, 32'h0);
    check("hold_lo", lo, 32'h00000001);

    // DIVU with same-edge MTHI, then divide by zero
    hi_we = 1'b1; wdata = 32'hDEAD;
    start_op(2'b01, 32'd100, 32'd7);
    hi_we = 1'b0;
    check("mthi_with_start", hi, 32'hDEAD);
    wait_done("divu_100_7", {1'b0, 32'd2, 32'd14}, 0, 0);
    start_op(2'b01, 32'd5, 32'd0);
    wait_done("divu_by0", {1'b1, 32'd5, 32'hFFFFFFFF}, 0, 0);

    // START and MTLO while busy are ignored; HI/LO hold mid-CALC
    start_op(2'b01, 32'd1000, 32'd9);
    repeat (5) step();
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd3; lo_we = 1'b1; wdata = 32'h1234;
    step();
    start = 1'b0; lo_we = 1'b0;
    check("mid_busy", {31'b0, busy}, 32'h1);
    check("mid_hi_stable", hi, 32'd5);
    check("mid_lo_stable", lo, 32'hFFFFFFFF);
    wait_done("divu_1000_9", {1'b0, 32'd1, 32'd111}, 6, 6);

    // Reset aborts an op
    start_op(2'b00, 32'd3, 32'd5);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    dseen = 1'b0;
    repeat (40) begin
      if (done !== 1'b0) dseen = 1'b1;
      step();
    end
    check("abort_no_done", {31'b0, dseen}, 32'h0);
    lo_we = 1'b1; wdata = 32'hABCD;
    step();
    lo_we = 1'b0;
    check("mtlo", lo, 32'hABCD);

    // Signed-op directed cases (unsigned results when the option is absent)
    start_op(2'b10, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_m3x5", SGN ? {1'b0, 64'hFFFFFFFF_FFFFFFF1} : {1'b0, 64'h00000004_FFFFFFF1}, 0, 0);
    start_op(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2", SGN ? {1'b0, 64'hFFFFFFFF_FFFFFFFD} : {1'b0, 64'h00000001_7FFFFFFC}, 0, 0);
    start_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_min_m1", SGN ? {1'b0, 64'h00000000_80000000} : {1'b0, 64'h80000000_00000000}, 0, 0);

    // Random back-to-back ops (each START lands in the DONE cycle)
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      start_op(ro, ra, rb);
      wait_done($sformatf("rnd%0d_op%0d", i, ro), ref_op(ro, ra, rb), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
